spi_px_master: RTL and testbench

- SPI initiator (mode 0, MSB first, full duplex) that drives the pixel-processing chip's SPI responder from an FPGA test harness or host-side fabric.
- Each frame shifts one pixel word out on MOSI and captures one result word from MISO.
- A valid/ready pixel stream enters on the fabric side; a one-cycle valid result stream leaves on the fabric side.

---
 rtl/spi_master_pkg.sv | 23 ++
 rtl/spi_dep_signal_synchronizer.sv | 24 ++
 rtl/spi_px_master.sv | 154 +++++++++++++++
 tb/tb_spi_px_master.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Shared types and defaults for the pixel SPI initiator.
// Frame sequencing: IDLE -> SETUP -> SHIFT_HI <-> SHIFT_LO -> DONE -> GAP -> IDLE.
package spi_master_pkg;

  localparam int unsigned MAX_PIXEL_BITS     = 24;
  localparam int unsigned CLK_DIV_DEFAULT    = 4;
  localparam int unsigned GAP_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftHi,
    StShiftLo,
    StDone,
    StGap
  } state_e;

  // Width of a counter that must hold values 0..n-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_dep_signal_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module spi_dep_signal_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d_i};
    end
  end

  assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/spi_px_master.sv
// Mode-0, MSB-first, full-duplex SPI initiator: one pixel word out, one result word in per frame.
// Requires PIXEL_BITS >= 3, CLK_DIV >= 4, GAP_CYCLES >= 1.
module spi_px_master
  import spi_master_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = MAX_PIXEL_BITS,
  parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int unsigned GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic [PIXEL_BITS-1:0] tx_px_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [PIXEL_BITS-1:0] rx_px_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_sck_o,
  output logic                  spi_cs_o,
  output logic                  spi_sdo_o,
  input  logic                  spi_sdi_i
);

  localparam int unsigned DivW = cnt_width(CLK_DIV);
  localparam int unsigned BitW = cnt_width(PIXEL_BITS + 1);
  localparam int unsigned GapW = cnt_width(GAP_CYCLES);

  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [BitW-1:0] BitsInit = BitW'(PIXEL_BITS);
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYCLES - 1);

  state_e                r_state;
  logic [DivW-1:0]       r_div;
  logic [BitW-1:0]       r_bits;
  logic [GapW-1:0]       r_gap;
  // MSB goes straight to MOSI on accept, so only the remaining bits are held here.
  logic [PIXEL_BITS-2:0] r_tx_sh;
  logic [PIXEL_BITS-1:0] r_rx_sh;
  logic [PIXEL_BITS-1:0] r_rx_px;
  logic                  r_rx_valid;
  logic                  r_ready;
  logic                  r_sck;
  logic                  r_cs;
  logic                  r_sdo;

  logic w_sdi;
  logic w_div_last;

  spi_dep_signal_synchronizer #(
    .STAGES    (2),
    .RESET_VAL (1'b0)
  ) u_sdi_sync (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .d_i      (spi_sdi_i),
    .q_o      (w_sdi)
  );

  assign w_div_last = (r_div == DivLast);

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state    <= StIdle;
      r_div      <= '0;
      r_bits     <= '0;
      r_gap      <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_rx_px    <= '0;
      r_rx_valid <= 1'b0;
      r_ready    <= 1'b1;
      r_sck      <= 1'b0;
      r_cs       <= 1'b1;
      r_sdo      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (tx_valid_i && r_ready) begin
            r_tx_sh <= tx_px_i[PIXEL_BITS-2:0];
            r_sdo   <= tx_px_i[PIXEL_BITS-1];
            r_bits  <= BitsInit;
            r_div   <= '0;
            r_cs    <= 1'b0;
            r_ready <= 1'b0;
            r_state <= StSetup;
          end
        end
        StSetup: begin
          if (w_div_last) begin
            r_div   <= '0;
            r_sck   <= 1'b1;
            r_state <= StShiftHi;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StShiftHi: begin
          if (w_div_last) begin
            // Sample at the end of the high phase so the synchronizer has settled.
            r_rx_sh <= {r_rx_sh[PIXEL_BITS-2:0], w_sdi};
            r_sdo   <= r_tx_sh[PIXEL_BITS-2];
            r_tx_sh <= {r_tx_sh[PIXEL_BITS-3:0], 1'b0};
            r_bits  <= r_bits - 1'b1;
            r_div   <= '0;
            r_sck   <= 1'b0;
            r_state <= StShiftLo;
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StShiftLo: begin
          if (w_div_last) begin
            r_div <= '0;
            if (r_bits == '0) begin
              r_cs       <= 1'b1;
              r_sdo      <= 1'b0;
              r_rx_px    <= r_rx_sh;
              r_rx_valid <= 1'b1;
              r_state    <= StDone;
            end else begin
              r_sck   <= 1'b1;
              r_state <= StShiftHi;
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StDone: begin
          r_gap   <= '0;
          r_state <= StGap;
        end
        StGap: begin
          if (r_gap == GapLast) begin
            r_ready <= 1'b1;
            r_state <= StIdle;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign tx_ready_o = r_ready;
  assign rx_px_o    = r_rx_px;
  assign rx_valid_o = r_rx_valid;
  assign busy_o     = (r_state != StIdle);
  assign spi_sck_o  = r_sck;
  assign spi_cs_o   = r_cs;
  assign spi_sdo_o  = r_sdo;

endmodule

// File: tb/tb_spi_px_master.sv
// Self-checking bench for spi_px_master: frame-timing model plus directed and random frames.
module tb_spi_px_master;

  localparam int PB  = 24;
  localparam int CD  = 4;
  localparam int GAP = 4;
  localparam int F   = 1 + CD * (2 * PB + 1);  // age of the DONE cycle, counted from accept

  logic          clk;
  logic          nreset;
  logic [PB-1:0] tx_px;
  logic          tx_valid;
  logic          tx_ready;
  logic [PB-1:0] rx_px;
  logic          rx_valid;
  logic          busy;
  logic          spi_sck;
  logic          spi_cs;
  logic          spi_sdo;
  logic          spi_sdi;

  spi_px_master #(
    .PIXEL_BITS (PB),
    .CLK_DIV    (CD),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_i      (clk),
    .nreset_i   (nreset),
    .tx_px_i    (tx_px),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .rx_px_o    (rx_px),
    .rx_valid_o (rx_valid),
    .busy_o     (busy),
    .spi_sck_o  (spi_sck),
    .spi_cs_o   (spi_cs),
    .spi_sdo_o  (spi_sdo),
    .spi_sdi_i  (spi_sdi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder: loopback, or a fixed word shifted out MSB first, changing on SCK fall.
  logic          loop;
  logic [PB-1:0] resp_word;
  logic [PB-1:0] cap;
  int            falls = 0;

  always @(negedge spi_sck or posedge spi_cs) begin
    if (spi_cs) falls <= 0;
    else        falls <= falls + 1;
  end
  always @(posedge spi_sck) cap <= {cap[PB-2:0], spi_sdo};
  assign spi_sdi = loop ? spi_sdo : ((falls < PB) ? resp_word[PB-1-falls] : 1'b0);

  // Model: a frame is just an age counter since accept; outputs derive from the age.
  logic          m_busy;
  int            m_age;
  logic [PB-1:0] m_tx;
  logic [PB-1:0] m_exp_rx;
  logic [PB-1:0] m_last_rx;

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_busy    <= 1'b0;
      m_age     <= 0;
      m_last_rx <= '0;
    end else if (!m_busy) begin
      if (tx_valid) begin
        m_busy   <= 1'b1;
        m_age    <= 1;
        m_tx     <= tx_px;
        m_exp_rx <= loop ? tx_px : resp_word;
      end
    end else begin
      if (m_age == F) m_last_rx <= m_exp_rx;
      if (m_age == F + GAP) m_busy <= 1'b0;
      m_age <= m_age + 1;
    end
  end

  logic prev_sck = 1'b0;
  logic prev_sdo = 1'b0;
  logic prev_cs  = 1'b1;
  int   rises    = 0;
  int   rxv_cnt  = 0;
  int   cs_run   = 0;
  int   last_run = 0;

  always @(negedge clk) begin
    logic          e_cs, e_sck, e_sdo, e_rdy, e_busy, e_rxv;
    logic [PB-1:0] e_rx;
    int            off, p, idx;
    e_cs = 1'b1; e_sck = 1'b0; e_sdo = 1'b0; e_rdy = 1'b1; e_busy = 1'b0; e_rxv = 1'b0;
    e_rx = m_last_rx;
    if (nreset && m_busy) begin
      e_rdy  = 1'b0;
      e_busy = 1'b1;
      if (m_age < F) begin
        e_cs = 1'b0;
        off  = m_age - 1;
        if (off < CD) begin
          idx = PB - 1;
        end else begin
          p = (off - CD) / CD;
          if (p % 2 == 0) begin
            e_sck = 1'b1;
            idx   = PB - 1 - p / 2;
          end else begin
            idx = PB - 2 - p / 2;
          end
        end
        e_sdo = (idx >= 0) ? m_tx[idx] : 1'b0;
      end else if (m_age == F) begin
        e_rxv = 1'b1;
        e_rx  = m_exp_rx;
      end
    end
    chk("cycle {cs,sck,sdo,ready,busy,rxv,rx}",
        64'({spi_cs, spi_sck, spi_sdo, tx_ready, busy, rx_valid, rx_px}),
        64'({e_cs, e_sck, e_sdo, e_rdy, e_busy, e_rxv, e_rx}));
    if (nreset && spi_sck && prev_sck) chk("mosi_stable_sck_high", 64'(spi_sdo), 64'(prev_sdo));
    if (m_busy && m_age == 1) rises <= 0;
    else if (spi_sck && !prev_sck) rises <= rises + 1;
    if (!spi_cs && prev_cs) begin
      last_run <= cs_run;
      cs_run   <= 0;
    end else if (nreset && spi_cs && !rx_valid) begin
      cs_run <= cs_run + 1;
    end
    rxv_cnt  <= rxv_cnt + (rx_valid ? 1 : 0);
    prev_sck <= spi_sck;
    prev_sdo <= spi_sdo;
    prev_cs  <= spi_cs;
  end

  int t0;
  int t_rx;

  task automatic wait_idle();
    int i;
    for (i = 0; i < 1000 && m_busy; i++) @(negedge clk);
    if (m_busy) chk("wait_idle_timeout", 64'(1), 64'(0));
  endtask

  task automatic send(input logic [PB-1:0] px);
    wait_idle();
    @(negedge clk);
    tx_px    = px;
    tx_valid = 1'b1;
    t0       = cyc;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx();
    int i;
    for (i = 0; i < 600 && !rx_valid; i++) @(negedge clk);
    if (!rx_valid) chk("rx_valid_timeout", 64'(0), 64'(1));
    t_rx = cyc;
    @(negedge clk);
  endtask

  initial begin
    int base;
    logic [PB-1:0] w;
    nreset    = 1'b0;
    tx_valid  = 1'b0;
    tx_px     = '0;
    loop      = 1'b1;
    resp_word = '0;
    cap       = '0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;

    // Reset idle
    repeat (100) @(negedge clk);
    chk("idle_no_rx_valid", 64'(rxv_cnt), 64'(0));

    // Loopback frame
    send(24'hA5C33C);
    wait_rx();
    chk("loop_latency", 64'(t_rx - t0), 64'(197));
    chk("loop_rx_px", 64'(rx_px), 64'(24'hA5C33C));
    chk("loop_sck_rises", 64'(rises), 64'(24));

    // Fixed-word responder
    wait_idle();
    loop      = 1'b0;
    resp_word = 24'h00003F;
    send(24'h123456);
    wait_rx();
    chk("resp_rx_px", 64'(rx_px), 64'(24'h00003F));
    chk("resp_captured_mosi", 64'(cap), 64'(24'h123456));

    // Back-to-back with tx_valid held
    wait_idle();
    loop = 1'b1;
    @(negedge clk);
    tx_px    = 24'd1;
    tx_valid = 1'b1;
    wait_rx();
    chk("b2b_rx1", 64'(rx_px), 64'(24'd1));
    base  = t_rx;
    tx_px = 24'd2;
    wait_rx();
    chk("b2b_rx2", 64'(rx_px), 64'(24'd2));
    chk("b2b_spacing12", 64'(t_rx - base), 64'(202));
    chk("b2b_cs_gap12", 64'(last_run), 64'(5));
    base  = t_rx;
    tx_px = 24'd3;
    wait_rx();
    tx_valid = 1'b0;
    chk("b2b_rx3", 64'(rx_px), 64'(24'd3));
    chk("b2b_spacing23", 64'(t_rx - base), 64'(202));
    chk("b2b_cs_gap23", 64'(last_run), 64'(5));

    // Reset mid-frame
    send(24'h0F0F0F);
    for (int i = 0; i < 400 && rises < 10; i++) @(negedge clk);
    chk("mid_reached_10_rises", 64'(rises >= 10), 64'(1));
    base = rxv_cnt;
    #2 nreset = 1'b0;
    #1;
    chk("mid_reset_cs", 64'(spi_cs), 64'(1));
    chk("mid_reset_sck", 64'(spi_sck), 64'(0));
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_no_rx_valid", 64'(rxv_cnt), 64'(base));
    send(24'hFFFFFF);
    wait_rx();
    chk("mid_next_frame_rx", 64'(rx_px), 64'(24'hFFFFFF));

    // Backpressure: valid pulses while busy are dropped
    send(24'h5A5A5A);
    repeat (50) @(negedge clk);
    tx_px    = 24'h111111;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_rx();
    chk("bp_rx_px", 64'(rx_px), 64'(24'h5A5A5A));
    tx_px    = 24'h222222;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("bp_no_new_frame", 64'(busy), 64'(0));

    // Random frames
    for (int k = 0; k < 8; k++) begin
      wait_idle();
      loop      = ($urandom % 2) == 1;
      resp_word = PB'($urandom);
      w         = PB'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      send(w);
      wait_rx();
      chk("rand_mosi", 64'(cap), 64'(w));
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
